oam_line_scanner: RTL

Parametrised per-scanline object (sprite) scanner for the Game Boy PPU. On each line start it walks OAM and selects up to MAX_PER_LINE objects vertically overlapping the current LY, using a fixed two-cycle-per-object read pattern. It then holds the selection in a slot buffer that the draw stage queries by X position and consumes in OAM-priority order. It sits between the PPU mode sequencer and the shared PPU memory read port.

---
 rtl/oam_scan_pkg.sv | 23 ++
 rtl/obj_slot_buffer.sv | 54 +++++
 rtl/oam_line_scanner.sv | 120 ++++++++++++
 3 files changed

// File: rtl/oam_scan_pkg.sv
// oam_scan_pkg: shared state encoding, offsets, slot record and OAM address helper for the line scanner.
package oam_scan_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

    localparam int Y_OFFSET = 16;
    localparam int X_OFFSET = 8;
    localparam logic [15:0] OAM_BASE_DEF = 16'hFE00;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
        logic [7:0] obj;
        logic       valid;
        logic       unconsumed;
    } slot_t;

    // Read k of the scan: even k fetches Y of object k/2, odd k fetches its X.
    function automatic logic [15:0] obj_addr(input logic [15:0] base, input int k);
        return base + 16'((k >> 1) * 4 + (k & 1));
    endfunction

endpackage

// File: rtl/obj_slot_buffer.sv
// obj_slot_buffer: per-line selected-object slots with X-match priority lookup and consume.
module obj_slot_buffer
    import oam_scan_pkg::*;
#(
    parameter int MAX_PER_LINE = 10,
    parameter int NUM_OBJ      = 40,
    localparam int SW = $clog2(MAX_PER_LINE),
    localparam int OW = $clog2(NUM_OBJ)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_idx,
    input  logic [7:0]    wr_y,
    input  logic [7:0]    wr_x,
    input  logic [7:0]    wr_obj,
    input  logic          en,
    input  logic [7:0]    q_x,
    input  logic          consume,
    output logic          hit,
    output logic [SW-1:0] hit_slot,
    output logic [OW-1:0] hit_obj,
    output logic [3:0]    hit_y
);

    slot_t slots [MAX_PER_LINE];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < MAX_PER_LINE; i++) slots[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < MAX_PER_LINE; i++) slots[i] <= '0;
        end else begin
            if (wr_en) slots[wr_idx] <= '{y: wr_y, x: wr_x, obj: wr_obj, valid: 1'b1, unconsumed: 1'b1};
            if (consume && hit) slots[hit_slot].unconsumed <= 1'b0;
        end
    end

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_slot = '0;
        for (int i = MAX_PER_LINE - 1; i >= 0; i--)
            if (en && slots[i].valid && slots[i].unconsumed && slots[i].x == q_x) begin
                hit      = 1'b1;
                hit_slot = SW'(i);
            end
    end

    assign hit_obj = slots[hit_slot].obj[OW-1:0];
    assign hit_y   = slots[hit_slot].y[3:0];

endmodule

// File: rtl/oam_line_scanner.sv
// oam_line_scanner: per-scanline OAM walk selecting up to MAX_PER_LINE objects; OAM_SCAN_TALL_EN enables 8x16 objects.
module oam_line_scanner
    import oam_scan_pkg::*;
#(
    parameter int          NUM_OBJ      = 40,
    parameter int          MAX_PER_LINE = 10,
    parameter logic [15:0] OAM_BASE     = OAM_BASE_DEF,
    localparam int CW = $clog2(MAX_PER_LINE + 1),
    localparam int SW = $clog2(MAX_PER_LINE),
    localparam int OW = $clog2(NUM_OBJ)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          start,
    input  logic [7:0]    ly,
    input  logic          tall,
    output logic          oam_rd,
    output logic [15:0]   oam_addr,
    input  logic [7:0]    oam_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    input  logic [7:0]    q_x,
    output logic          hit,
    output logic [SW-1:0] hit_slot,
    output logic [OW-1:0] hit_obj,
    output logic [3:0]    hit_row,
    input  logic          consume
);

`ifdef OAM_SCAN_TALL_EN
    localparam bit TALL_EN = 1'b1;
`else
    localparam bit TALL_EN = 1'b0;
`endif

    localparam int KW   = $clog2(2 * NUM_OBJ + 1);
    localparam int LAST = 2 * NUM_OBJ - 1;

    state_t        state;
    logic [KW-1:0] k, dk;
    logic          dv, pending, tall_q, in_range, wr_en;
    logic [7:0]    ly_q, y_q;
    logic [8:0]    ly16, h;
    logic [3:0]    hit_y;

    assign ly16     = 9'(ly_q) + 9'(Y_OFFSET);
    assign h        = (TALL_EN && tall_q) ? 9'd16 : 9'd8;
    assign in_range = ly16 >= {1'b0, oam_data} && ly16 < {1'b0, oam_data} + h;
    assign wr_en    = state == SCAN && dv && dk[0] && pending && count < CW'(MAX_PER_LINE);
    assign hit_row  = (ly_q[3:0] - hit_y) & {TALL_EN, 3'b111};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            k        <= '0;
            dk       <= '0;
            dv       <= 1'b0;
            pending  <= 1'b0;
            ly_q     <= '0;
            y_q      <= '0;
            tall_q   <= 1'b0;
            count    <= '0;
            oam_rd   <= 1'b0;
            oam_addr <= OAM_BASE;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state    <= SCAN;
                k        <= '0;
                dv       <= 1'b0;
                pending  <= 1'b0;
                ly_q     <= ly;
                tall_q   <= tall;
                count    <= '0;
                oam_rd   <= 1'b1;
                oam_addr <= OAM_BASE;
                busy     <= 1'b1;
            end else if (state == SCAN) begin
                // k is the read on the bus now; dk is the read whose data is arriving.
                dv <= k <= KW'(LAST);
                dk <= k;
                if (k <= KW'(LAST)) k <= k + 1'b1;
                if (k < KW'(LAST)) oam_addr <= obj_addr(OAM_BASE, int'(k) + 1);
                if (dv && !dk[0]) begin
                    pending <= in_range;
                    y_q     <= oam_data;
                end
                if (wr_en) count <= count + 1'b1;
                if (dv && dk == KW'(LAST)) begin
                    state  <= READY;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    oam_rd <= 1'b0;
                end
            end
        end
    end

    obj_slot_buffer #(.MAX_PER_LINE(MAX_PER_LINE), .NUM_OBJ(NUM_OBJ)) u_slots (
        .clk      (clk),
        .rstN     (rstN),
        .clear    (start),
        .wr_en    (wr_en),
        .wr_idx   (count[SW-1:0]),
        .wr_y     (y_q),
        .wr_x     (oam_data),
        .wr_obj   (8'(dk >> 1)),
        .en       (state == READY),
        .q_x      (q_x),
        .consume  (consume),
        .hit      (hit),
        .hit_slot (hit_slot),
        .hit_obj  (hit_obj),
        .hit_y    (hit_y)
    );

endmodule
